// File: rtl/spi32_slave.sv
// spi32_slave: SPI mode-0 slave that receives and transmits up to 32 bits per
// chip-select window, with all SPI pins sampled into the clk domain.
//
// Ports:
//   clk_i        system clock, all logic on its rising edge
//   reset_ni     synchronous active-low reset
//   din_i        word to transmit on MISO, MSB byte first
//   load_i       one-cycle strobe capturing din_i for the next transaction
//   dout_o       received complete bytes, right-aligned, zero-extended
//   rx_nbytes_o  number of complete bytes in dout_o (1..4)
//   rx_valid_o   one-cycle pulse when dout_o/rx_nbytes_o update
//   overrun_o    pulses with rx_valid_o when more than 32 sclk edges were seen
//   busy_o       high while a transaction is active
//   sclk_i       SPI clock (asynchronous, CPOL=0 CPHA=0)
//   cs_i         active-low chip select (asynchronous)
//   sdi_i        MOSI (asynchronous)
//   sdo_o        MISO, always driven
module spi32_slave #(
  parameter int SYNC_STAGES = 2  // 2..3
) (
  input  logic        clk_i,
  input  logic        reset_ni,
  input  logic [31:0] din_i,
  input  logic        load_i,
  output logic [31:0] dout_o,
  output logic [2:0]  rx_nbytes_o,
  output logic        rx_valid_o,
  output logic        overrun_o,
  output logic        busy_o,
  input  logic        sclk_i,
  input  logic        cs_i,
  input  logic        sdi_i,
  output logic        sdo_o
);

  typedef enum logic [1:0] {WAIT_HIGH, IDLE, ACTIVE} state_t;

  // Cycles to spend in WAIT_HIGH after reset before trusting the cs
  // synchronizer: its reset value of 1 must be flushed by the real pin level.
  localparam logic [1:0] SETTLE = 2'(SYNC_STAGES);

  logic [SYNC_STAGES-1:0] sclk_sync_q, cs_sync_q, sdi_sync_q;
  logic                   sclk_d1_q, cs_d1_q;
  logic                   sclk_s, cs_s, sdi_s;
  logic                   sclk_rise, sclk_fall, cs_rise, cs_fall;

  state_t      state_q;
  logic [1:0]  settle_q;
  logic [31:0] rx_sr_q;
  logic [5:0]  cnt_q;
  logic [31:0] tx_q;
  logic        tx_pending_q;
  logic        done_q;
  logic [31:0] dout_q;
  logic [2:0]  rx_nbytes_q;
  logic        rx_valid_q, overrun_q, busy_q, sdo_q;
  logic [31:0] dout_d;
  logic [2:0]  rx_nbytes_d;

  // Input synchronizers plus one extra registered copy for edge detection.
  always_ff @(posedge clk_i) begin
    if (!reset_ni) begin
      sclk_sync_q <= '0;
      cs_sync_q   <= '1;
      sdi_sync_q  <= '0;
      sclk_d1_q   <= 1'b0;
      cs_d1_q     <= 1'b1;
    end else begin
      sclk_sync_q <= {sclk_sync_q[SYNC_STAGES-2:0], sclk_i};
      cs_sync_q   <= {cs_sync_q[SYNC_STAGES-2:0], cs_i};
      sdi_sync_q  <= {sdi_sync_q[SYNC_STAGES-2:0], sdi_i};
      sclk_d1_q   <= sclk_sync_q[SYNC_STAGES-1];
      cs_d1_q     <= cs_sync_q[SYNC_STAGES-1];
    end
  end

  assign sclk_s    = sclk_sync_q[SYNC_STAGES-1];
  assign cs_s      = cs_sync_q[SYNC_STAGES-1];
  assign sdi_s     = sdi_sync_q[SYNC_STAGES-1];
  assign sclk_rise = sclk_s & ~sclk_d1_q;
  assign sclk_fall = ~sclk_s & sclk_d1_q;
  assign cs_rise   = cs_s & ~cs_d1_q;
  assign cs_fall   = ~cs_s & cs_d1_q;

  // Receive extraction: the shift register holds cnt bits right-aligned, so
  // dropping the trailing partial byte is a right shift by cnt mod 8. Bits
  // above the received count are still zero from the clear on entry.
  always_comb begin
    dout_d      = rx_sr_q;
    rx_nbytes_d = 3'd4;
    if (cnt_q < 6'd32) begin
      dout_d      = rx_sr_q >> cnt_q[2:0];
      rx_nbytes_d = {1'b0, cnt_q[4:3]};
    end
  end

  always_ff @(posedge clk_i) begin
    if (!reset_ni) begin
      state_q      <= WAIT_HIGH;
      settle_q     <= '0;
      rx_sr_q      <= '0;
      cnt_q        <= '0;
      tx_q         <= '0;
      tx_pending_q <= 1'b0;
      done_q       <= 1'b0;
      dout_q       <= '0;
      rx_nbytes_q  <= '0;
      rx_valid_q   <= 1'b0;
      overrun_q    <= 1'b0;
      busy_q       <= 1'b0;
      sdo_q        <= 1'b0;
    end else begin
      rx_valid_q <= 1'b0;
      overrun_q  <= 1'b0;
      done_q     <= 1'b0;

      // Results are published one cycle after the cs rise; the edge count and
      // shift register stay intact until the next transaction starts.
      if (done_q) begin
        rx_valid_q  <= 1'b1;
        dout_q      <= dout_d;
        rx_nbytes_q <= rx_nbytes_d;
        overrun_q   <= (cnt_q == 6'd33);
      end

      case (state_q)
        WAIT_HIGH: begin
          if (settle_q != SETTLE) settle_q <= settle_q + 2'd1;
          else if (cs_s)          state_q  <= IDLE;
          if (load_i) begin
            tx_q         <= din_i;
            tx_pending_q <= 1'b1;
          end
        end

        IDLE: begin
          if (load_i) begin
            tx_q         <= din_i;
            tx_pending_q <= 1'b1;
          end
          if (cs_fall) begin
            state_q <= ACTIVE;
            busy_q  <= 1'b1;
            cnt_q   <= '0;
            rx_sr_q <= '0;
            // A load coinciding with the cs fall takes precedence.
            sdo_q   <= load_i ? din_i[31] : (tx_pending_q & tx_q[31]);
          end
        end

        ACTIVE: begin
          if (cs_rise) begin
            state_q      <= IDLE;
            busy_q       <= 1'b0;
            sdo_q        <= 1'b0;
            tx_q         <= '0;
            tx_pending_q <= 1'b0;
            done_q       <= (cnt_q >= 6'd8);
          end else begin
            if (sclk_rise) begin
              if (cnt_q < 6'd32)  rx_sr_q <= {rx_sr_q[30:0], sdi_s};
              if (cnt_q != 6'd33) cnt_q   <= cnt_q + 6'd1;
            end
            if (sclk_fall) begin
              tx_q  <= {tx_q[30:0], 1'b0};
              sdo_q <= tx_q[30];
            end
          end
        end

        default: state_q <= WAIT_HIGH;
      endcase
    end
  end

  assign dout_o      = dout_q;
  assign rx_nbytes_o = rx_nbytes_q;
  assign rx_valid_o  = rx_valid_q;
  assign overrun_o   = overrun_q;
  assign busy_o      = busy_q;
  assign sdo_o       = sdo_q;

endmodule

// File: tb/tb_spi32_slave.sv
// tb_spi32_slave: directed SPI transactions against spi32_slave. Expected
// receive results are queued by the stimulus; a monitor pops and compares
// them whenever rx_valid is seen. MISO, busy and latency are checked inline.
module tb_spi32_slave;

  localparam int SS = 2;  // synchronizer depth
  localparam int H  = 8;  // sclk half period in clk cycles

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [31:0] din = '0;
  logic        load = 1'b0;
  logic [31:0] dout;
  logic [2:0]  rx_nbytes;
  logic        rx_valid, overrun, busy;
  logic        sclk = 1'b0;
  logic        cs = 1'b1;
  logic        sdi = 1'b0;
  logic        sdo;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [31:0] d;
    logic [2:0]  n;
    logic        o;
  } exp_t;
  exp_t exp_q[$];

  always #5 clk = ~clk;

  spi32_slave #(.SYNC_STAGES(SS)) dut (
    .clk_i(clk), .reset_ni(reset_n), .din_i(din), .load_i(load),
    .dout_o(dout), .rx_nbytes_o(rx_nbytes), .rx_valid_o(rx_valid),
    .overrun_o(overrun), .busy_o(busy),
    .sclk_i(sclk), .cs_i(cs), .sdi_i(sdi), .sdo_o(sdo)
  );

  task automatic chk(input string name, input logic [39:0] act, input logic [39:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  // Monitor: compares each rx_valid pulse against the scoreboard.
  initial begin
    logic prev = 1'b0;
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (rx_valid) begin
        chk("rx_valid_width", {39'd0, prev}, 40'd0);
        if (exp_q.size() == 0) begin
          chk("unexpected_rx_valid", 40'd1, 40'd0);
        end else begin
          e = exp_q.pop_front();
          chk("dout", {8'd0, dout}, {8'd0, e.d});
          chk("rx_nbytes", {37'd0, rx_nbytes}, {37'd0, e.n});
          chk("overrun", {39'd0, overrun}, {39'd0, e.o});
          $display("rx dout=%h nbytes=%0d overrun=%0d", dout, rx_nbytes, overrun);
        end
      end else if (overrun) begin
        chk("overrun_without_valid", 40'd1, 40'd0);
      end
      prev = rx_valid;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic wait_clks(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse_load(input logic [31:0] v);
    din  = v;
    load = 1'b1;
    @(negedge clk);
    load = 1'b0;
  endtask

  // n sclk periods with cs already low; MISO sampled just before each rise.
  task automatic spi_bits(input int n, input logic [39:0] mosi, input int load_edge,
                          input logic [31:0] load_val, output logic [39:0] miso);
    miso = '0;
    for (int i = 0; i < n; i++) begin
      sdi = mosi[n-1-i];
      if (i == load_edge) pulse_load(load_val);
      wait_clks(H);
      miso = {miso[38:0], sdo};
      sclk = 1'b1;
      wait_clks(H);
      sclk = 1'b0;
    end
  endtask

  task automatic spi_xfer(input int n, input logic [39:0] mosi, input int load_edge,
                          input logic [31:0] load_val, input bit at_fall,
                          input logic [31:0] fall_val, input bit expect_valid,
                          output logic [39:0] miso);
    int  cyc;
    bit  seen;
    cs = 1'b0;
    if (at_fall) begin
      // Load lands on the same clk edge that registers the cs fall.
      wait_clks(SS);
      pulse_load(fall_val);
      wait_clks(H - SS - 1);
    end else begin
      wait_clks(H);
    end
    chk("busy_active", {39'd0, busy}, 40'd1);
    spi_bits(n, mosi, load_edge, load_val, miso);
    wait_clks(H);
    cs = 1'b1;
    if (expect_valid) begin
      cyc  = 0;
      seen = 1'b0;
      while (!seen && cyc < 20) begin
        @(posedge clk);
        #1;
        cyc++;
        if (rx_valid) seen = 1'b1;
      end
      chk("rx_latency", seen ? 40'(cyc) : 40'd0, 40'(SS + 2));
      @(negedge clk);
    end
    wait_clks(12);
    chk("busy_idle", {39'd0, busy}, 40'd0);
    chk("sdo_idle", {39'd0, sdo}, 40'd0);
  endtask

  initial begin
    logic [39:0] miso;

    // Reset state
    wait_clks(4);
    chk("reset_dout", {8'd0, dout}, 40'd0);
    chk("reset_nbytes", {37'd0, rx_nbytes}, 40'd0);
    chk("reset_ctrl", {35'd0, rx_valid, overrun, busy, sdo, 1'b0}, 40'd0);
    reset_n = 1'b1;
    wait_clks(10);

    // 4-byte transfer with preloaded MISO word
    pulse_load(32'hA5C3_0F81);
    exp_q.push_back('{d: 32'h1234_5678, n: 3'd4, o: 1'b0});
    spi_xfer(32, 40'h12345678, -1, '0, 1'b0, '0, 1'b1, miso);
    $display("xfer 32 edges miso=%h", miso[31:0]);
    chk("miso_4byte", {8'd0, miso[31:0]}, 40'hA5C30F81);

    // 1-byte transfer with load; next transfer must not resend it
    pulse_load(32'hC300_0000);
    exp_q.push_back('{d: 32'h0000_0081, n: 3'd1, o: 1'b0});
    spi_xfer(8, 40'h81, -1, '0, 1'b0, '0, 1'b1, miso);
    $display("xfer 8 edges miso=%h", miso[7:0]);
    chk("miso_1byte_load", {32'd0, miso[7:0]}, 40'hC3);

    exp_q.push_back('{d: 32'h0000_009E, n: 3'd1, o: 1'b0});
    spi_xfer(8, 40'h9E, -1, '0, 1'b0, '0, 1'b1, miso);
    $display("xfer 8 edges miso=%h", miso[7:0]);
    chk("miso_no_load", {32'd0, miso[7:0]}, 40'h00);

    // 13 edges: partial trailing bits discarded
    exp_q.push_back('{d: 32'h0000_00F0, n: 3'd1, o: 1'b0});
    spi_xfer(13, {27'd0, 8'hF0, 5'b10101}, -1, '0, 1'b0, '0, 1'b1, miso);
    $display("xfer 13 edges miso=%h", miso[12:0]);
    chk("miso_13", {27'd0, miso[12:0]}, 40'h0);

    // 5 edges: no rx_valid, dout holds
    spi_xfer(5, 40'h1F, -1, '0, 1'b0, '0, 1'b0, miso);
    $display("xfer 5 edges dout=%h", dout);
    chk("dout_hold_short", {8'd0, dout}, 40'hF0);

    // 40 edges: overrun, first 32 bits kept
    exp_q.push_back('{d: 32'hDEAD_BEEF, n: 3'd4, o: 1'b1});
    spi_xfer(40, 40'hDEADBEEF77, -1, '0, 1'b0, '0, 1'b1, miso);
    $display("xfer 40 edges miso=%h", miso);

    // Reset in the middle of a transaction, released with cs still low
    cs = 1'b0;
    wait_clks(H);
    spi_bits(12, 40'hABC, -1, '0, miso);
    reset_n = 1'b0;
    wait_clks(4);
    chk("busy_in_reset", {39'd0, busy}, 40'd0);
    reset_n = 1'b1;
    wait_clks(H);
    chk("busy_after_reset_cs_low", {39'd0, busy}, 40'd0);
    spi_bits(8, 40'h5A, -1, '0, miso);
    wait_clks(H);
    cs = 1'b1;
    wait_clks(12);
    $display("xfer after reset dout=%h busy=%0d", dout, busy);
    chk("dout_after_reset", {8'd0, dout}, 40'd0);

    exp_q.push_back('{d: 32'h0000_BEEF, n: 3'd2, o: 1'b0});
    spi_xfer(16, 40'hBEEF, -1, '0, 1'b0, '0, 1'b1, miso);
    $display("xfer 16 edges miso=%h", miso[15:0]);

    // Load during ACTIVE is ignored
    exp_q.push_back('{d: 32'h0000_003C, n: 3'd1, o: 1'b0});
    spi_xfer(8, 40'h3C, 3, 32'hFFFF_FFFF, 1'b0, '0, 1'b1, miso);
    $display("xfer 8 edges load-in-active miso=%h", miso[7:0]);
    chk("miso_load_active", {32'd0, miso[7:0]}, 40'h00);

    // Load coinciding with the cs fall wins
    exp_q.push_back('{d: 32'h0000_0055, n: 3'd1, o: 1'b0});
    spi_xfer(8, 40'h55, -1, '0, 1'b1, 32'h8000_0000, 1'b1, miso);
    $display("xfer 8 edges load-at-fall miso=%h", miso[7:0]);
    chk("miso_load_at_fall", {32'd0, miso[7:0]}, 40'h80);

    wait_clks(20);
    chk("scoreboard_drained", 40'(exp_q.size()), 40'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
